// File: rtl/rv32i_single_cycle_core.sv
// rv32i_single_cycle_core: single-cycle RV32I integer core (one instruction retired per clk).
// Ports:
//   clk        rising-edge clock; PC and register file update on this edge
//   reset      asynchronous active-low reset (PC <= RESET_PC, registers cleared)
//   instr      instruction word at pc_out, combinational from instruction memory
//   read_data  load data at alu_result, combinational from data RAM
//   pc_out     current PC (byte address)
//   write_en   store strobe; RAM captures write_data at alu_result on the next rising clk
//   write_data store data (rs2 value)
//   alu_result ALU output; effective address for LW/SW
module rv32i_single_cycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic [31:0] read_data,
   output logic [31:0] pc_out,
   output logic        write_en,
   output logic [31:0] write_data,
   output logic [31:0] alu_result
);
   localparam int unsigned NREGS = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic [31:0] pc;
   logic [31:0] regs [NREGS];

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] rd_data;
   logic        reg_we;
   logic        store;
   logic        taken;
   logic        r_legal;
   logic        i_legal;

   // Instruction field and immediate extraction
   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'h000};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Register read ports; x0 is hard-wired to zero
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
   assign pc_plus4 = pc + 32'd4;

   // funct7 must be all-zero except the SUB/SRA alternate encodings
   assign r_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
   assign i_legal = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                    (funct3 == 3'b101) ? ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) :
                    1'b1;

   function automatic logic [31:0] alu(input logic [2:0]  f3,
                                       input logic        alt,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (f3)
         3'b000:  alu = alt ? (a - b) : (a + b);
         3'b001:  alu = a << sh;
         3'b010:  alu = {31'd0, ($signed(a) < $signed(b))};
         3'b011:  alu = {31'd0, (a < b)};
         3'b100:  alu = a ^ b;
         3'b101:  alu = alt ? 32'($signed(a) >>> sh) : (a >> sh);
         3'b110:  alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   // Branch condition on the two register operands
   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (rs1_val == rs2_val);
         3'b001:  taken = (rs1_val != rs2_val);
         3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  taken = (rs1_val <  rs2_val);
         3'b111:  taken = (rs1_val >= rs2_val);
         default: taken = 1'b0;
      endcase
   end

   // Main decode / execute; anything unrecognised falls through as a NOP
   always_comb begin
      alu_result = 32'd0;
      rd_data    = 32'd0;
      reg_we     = 1'b0;
      store      = 1'b0;
      next_pc    = pc_plus4;
      case (opcode)
         OP_R: begin
            alu_result = alu(funct3, funct7[5], rs1_val, rs2_val);
            rd_data    = alu_result;
            reg_we     = r_legal;
         end
         OP_I: begin
            alu_result = alu(funct3, (funct3 == 3'b101) && funct7[5], rs1_val, imm_i);
            rd_data    = alu_result;
            reg_we     = i_legal;
         end
         OP_LOAD: begin
            alu_result = rs1_val + imm_i;
            rd_data    = read_data;
            reg_we     = (funct3 == 3'b010);
         end
         OP_STORE: begin
            alu_result = rs1_val + imm_s;
            store      = (funct3 == 3'b010);
         end
         OP_BRANCH: begin
            alu_result = rs1_val - rs2_val;
            if (taken) next_pc = pc + imm_b;
         end
         OP_JAL: begin
            rd_data = pc_plus4;
            reg_we  = 1'b1;
            next_pc = pc + imm_j;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               alu_result = rs1_val + imm_i;
               rd_data    = pc_plus4;
               reg_we     = 1'b1;
               next_pc    = alu_result & ~32'd1;
            end
         end
         OP_LUI: begin
            alu_result = imm_u;
            rd_data    = imm_u;
            reg_we     = 1'b1;
         end
         OP_AUIPC: begin
            alu_result = pc + imm_u;
            rd_data    = alu_result;
            reg_we     = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_out     = pc;
   assign write_data = rs2_val;
   assign write_en   = store & reset;

   // PC and register file; reset aborts the instruction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else begin
         pc <= next_pc;
         if (reg_we && (rd != 5'd0)) regs[rd] <= rd_data;
      end
   end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb_rv32i_single_cycle_core: checks the core against an instruction-level model
// driven from a structured program (directed section + random section + register dump).
module tb_rv32i_single_cycle_core;
   typedef enum {
      I_ADD, I_SUB, I_SLL, I_SLT, I_SLTU, I_XOR, I_SRL, I_SRA, I_OR, I_AND,
      I_ADDI, I_SLTI, I_SLTIU, I_XORI, I_ORI, I_ANDI, I_SLLI, I_SRLI, I_SRAI,
      I_LW, I_SW, I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU,
      I_JAL, I_JALR, I_LUI, I_AUIPC, I_RAW
   } op_e;

   typedef struct {
      op_e         op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] raw;
   } ins_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr;
   logic [31:0] read_data;
   logic [31:0] pc_out;
   logic        write_en;
   logic [31:0] write_data;
   logic [31:0] alu_result;

   logic [31:0] imem [256];
   logic [31:0] dram [256];
   ins_t        prog [256];

   logic [31:0] m_pc;
   logic [31:0] m_regs [32];
   logic [31:0] mram [256];

   int checks = 0;
   int failures = 0;

   rv32i_single_cycle_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .read_data  (read_data),
      .pc_out     (pc_out),
      .write_en   (write_en),
      .write_data (write_data),
      .alu_result (alu_result)
   );

   always #5 clk = ~clk;

   assign instr     = imem[pc_out[9:2]];
   assign read_data = dram[alu_result[9:2]];

   always @(posedge clk) if (write_en) dram[alu_result[9:2]] <= write_data;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, logic [31:0] imm);
      ins_t x;
      x.op = op; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm; x.raw = 32'd0;
      return x;
   endfunction

   function automatic ins_t mkraw(logic [31:0] w);
      ins_t x;
      x = mk(I_RAW, 0, 0, 0, 32'd0);
      x.raw = w;
      return x;
   endfunction

   function automatic logic [31:0] enc(ins_t x);
      logic [31:0] m;
      logic [2:0]  bf;
      m = x.imm;
      bf = 3'd0;
      case (x.op)
         I_BNE:  bf = 3'd1;
         I_BLT:  bf = 3'd4;
         I_BGE:  bf = 3'd5;
         I_BLTU: bf = 3'd6;
         I_BGEU: bf = 3'd7;
         default: bf = 3'd0;
      endcase
      case (x.op)
         I_ADD:   return {7'h00, x.rs2, x.rs1, 3'd0, x.rd, 7'h33};
         I_SUB:   return {7'h20, x.rs2, x.rs1, 3'd0, x.rd, 7'h33};
         I_SLL:   return {7'h00, x.rs2, x.rs1, 3'd1, x.rd, 7'h33};
         I_SLT:   return {7'h00, x.rs2, x.rs1, 3'd2, x.rd, 7'h33};
         I_SLTU:  return {7'h00, x.rs2, x.rs1, 3'd3, x.rd, 7'h33};
         I_XOR:   return {7'h00, x.rs2, x.rs1, 3'd4, x.rd, 7'h33};
         I_SRL:   return {7'h00, x.rs2, x.rs1, 3'd5, x.rd, 7'h33};
         I_SRA:   return {7'h20, x.rs2, x.rs1, 3'd5, x.rd, 7'h33};
         I_OR:    return {7'h00, x.rs2, x.rs1, 3'd6, x.rd, 7'h33};
         I_AND:   return {7'h00, x.rs2, x.rs1, 3'd7, x.rd, 7'h33};
         I_ADDI:  return {m[11:0], x.rs1, 3'd0, x.rd, 7'h13};
         I_SLTI:  return {m[11:0], x.rs1, 3'd2, x.rd, 7'h13};
         I_SLTIU: return {m[11:0], x.rs1, 3'd3, x.rd, 7'h13};
         I_XORI:  return {m[11:0], x.rs1, 3'd4, x.rd, 7'h13};
         I_ORI:   return {m[11:0], x.rs1, 3'd6, x.rd, 7'h13};
         I_ANDI:  return {m[11:0], x.rs1, 3'd7, x.rd, 7'h13};
         I_SLLI:  return {7'h00, m[4:0], x.rs1, 3'd1, x.rd, 7'h13};
         I_SRLI:  return {7'h00, m[4:0], x.rs1, 3'd5, x.rd, 7'h13};
         I_SRAI:  return {7'h20, m[4:0], x.rs1, 3'd5, x.rd, 7'h13};
         I_LW:    return {m[11:0], x.rs1, 3'd2, x.rd, 7'h03};
         I_SW:    return {m[11:5], x.rs2, x.rs1, 3'd2, m[4:0], 7'h23};
         I_BEQ, I_BNE, I_BLT, I_BGE, I_BLTU, I_BGEU:
                  return {m[12], m[10:5], x.rs2, x.rs1, bf, m[4:1], m[11], 7'h63};
         I_JAL:   return {m[20], m[10:1], m[11], m[19:12], x.rd, 7'h6F};
         I_JALR:  return {m[11:0], x.rs1, 3'd0, x.rd, 7'h67};
         I_LUI:   return {m[19:0], x.rd, 7'h37};
         I_AUIPC: return {m[19:0], x.rd, 7'h17};
         default: return x.raw;
      endcase
   endfunction

   function automatic logic [31:0] simm12();
      logic [31:0] r;
      r = $urandom;
      return {{20{r[11]}}, r[11:0]};
   endfunction

   task automatic put(int addr, ins_t x);
      prog[addr / 4] = x;
      imem[addr / 4] = enc(x);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) put(i * 4, mk(I_ADDI, 0, 0, 0, 32'd0));
   endtask

   task automatic model_reset();
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s pc=%h observed=%h expected=%h", tag, m_pc, obs, exp);
      end
   endtask

   // Check one instruction's visible outputs, retire it in the model, move to the next cycle
   task automatic step();
      ins_t        x;
      logic [31:0] a, b, res, wv, npc;
      bit          st, wr, use_alu;
      #1;
      x = prog[m_pc[9:2]];
      a = m_regs[x.rs1];
      b = m_regs[x.rs2];
      npc = m_pc + 32'd4;
      res = 32'd0; wv = 32'd0; st = 0; wr = 0; use_alu = 1;
      case (x.op)
         I_ADD:   res = a + b;
         I_SUB:   res = a - b;
         I_SLL:   res = a << b[4:0];
         I_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         I_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
         I_XOR:   res = a ^ b;
         I_SRL:   res = a >> b[4:0];
         I_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
         I_OR:    res = a | b;
         I_AND:   res = a & b;
         I_ADDI:  res = a + x.imm;
         I_SLTI:  res = ($signed(a) < $signed(x.imm)) ? 32'd1 : 32'd0;
         I_SLTIU: res = (a < x.imm) ? 32'd1 : 32'd0;
         I_XORI:  res = a ^ x.imm;
         I_ORI:   res = a | x.imm;
         I_ANDI:  res = a & x.imm;
         I_SLLI:  res = a << x.imm[4:0];
         I_SRLI:  res = a >> x.imm[4:0];
         I_SRAI:  res = $unsigned($signed(a) >>> x.imm[4:0]);
         I_LW:    begin res = a + x.imm; wr = 1; wv = mram[res[9:2]]; end
         I_SW:    begin res = a + x.imm; st = 1; end
         I_BEQ:   begin res = a - b; if (a == b) npc = m_pc + x.imm; end
         I_BNE:   begin res = a - b; if (a != b) npc = m_pc + x.imm; end
         I_BLT:   begin res = a - b; if ($signed(a) < $signed(b)) npc = m_pc + x.imm; end
         I_BGE:   begin res = a - b; if ($signed(a) >= $signed(b)) npc = m_pc + x.imm; end
         I_BLTU:  begin res = a - b; if (a < b) npc = m_pc + x.imm; end
         I_BGEU:  begin res = a - b; if (a >= b) npc = m_pc + x.imm; end
         I_JAL:   begin use_alu = 0; wr = 1; wv = m_pc + 32'd4; npc = m_pc + x.imm; end
         I_JALR:  begin res = a + x.imm; wr = 1; wv = m_pc + 32'd4; npc = res & ~32'd1; end
         I_LUI:   begin use_alu = 0; wr = 1; wv = x.imm << 12; end
         I_AUIPC: begin use_alu = 0; wr = 1; wv = m_pc + (x.imm << 12); end
         default: use_alu = 0;
      endcase
      if (x.op <= I_SRAI) begin wr = 1; wv = res; end
      chk("pc", pc_out, m_pc);
      chk("write_en", {31'd0, write_en}, {31'd0, st});
      if (use_alu) chk("alu_result", alu_result, res);
      if (st) chk("write_data", write_data, b);
      if (st) mram[res[9:2]] = b;
      if (wr && x.rd != 5'd0) m_regs[x.rd] = wv;
      m_pc = npc;
      @(negedge clk);
   endtask

   task automatic run_to(logic [31:0] stop, int max);
      int n;
      n = 0;
      while (m_pc != stop && n < max) begin
         step();
         n++;
      end
      if (n >= max) begin
         checks++;
         failures++;
         $error("FAIL run_to observed_pc=%h expected_pc=%h", m_pc, stop);
      end
   endtask

   initial begin
      int a;
      int k;
      for (int i = 0; i < 256; i++) begin
         dram[i] = 32'hA5A5_0000 | 32'(i);
         mram[i] = 32'hA5A5_0000 | 32'(i);
      end
      clear_prog();

      // Directed section
      put(32'h00, mk(I_ADDI, 1, 0, 0, 32'd7));
      put(32'h04, mk(I_SW,   0, 0, 1, 32'h60));
      put(32'h08, mk(I_ADDI, 2, 0, 0, 32'd25));
      put(32'h0c, mk(I_SW,   0, 0, 2, 32'h64));
      put(32'h10, mk(I_LW,   3, 0, 0, 32'h60));
      put(32'h14, mk(I_ADD,  4, 3, 3, 32'd0));
      put(32'h18, mk(I_BEQ,  0, 1, 1, 32'd8));
      put(32'h1c, mk(I_SW,   0, 0, 1, 32'h70));
      put(32'h20, mk(I_JAL,  5, 0, 0, 32'd8));
      put(32'h24, mk(I_JAL,  0, 0, 0, 32'd16));
      put(32'h28, mk(I_JALR, 0, 5, 0, 32'd0));
      put(32'h2c, mk(I_SW,   0, 0, 1, 32'h44));
      put(32'h30, mk(I_SW,   0, 0, 1, 32'h44));
      put(32'h34, mk(I_BNE,  0, 1, 1, 32'd8));
      put(32'h38, mk(I_SW,   0, 0, 4, 32'h68));
      put(32'h3c, mk(I_ADDI, 0, 0, 0, 32'd5));
      put(32'h40, mk(I_SW,   0, 0, 0, 32'h6c));
      put(32'h44, mkraw(32'h0000_000F));
      put(32'h48, mkraw(32'h0000_0073));
      put(32'h4c, mkraw(32'hFFFF_FFFF));
      put(32'h50, mk(I_LUI,   6, 0, 0, 32'h80000));
      put(32'h54, mk(I_AUIPC, 7, 0, 0, 32'h00001));
      put(32'h58, mk(I_SUB,  8, 2, 1, 32'd0));
      put(32'h5c, mk(I_ADDI, 9, 0, 0, 32'hFFFF_FFFF));
      put(32'h60, mk(I_SRAI, 10, 9, 0, 32'd4));
      put(32'h64, mk(I_SRLI, 11, 9, 0, 32'd28));
      put(32'h68, mk(I_SLTU, 12, 1, 9, 32'd0));
      put(32'h6c, mk(I_SLT,  13, 9, 1, 32'd0));
      put(32'h70, mk(I_BLT,  0, 9, 1, 32'd8));
      put(32'h74, mk(I_SW,   0, 0, 9, 32'h78));
      put(32'h78, mk(I_BGEU, 0, 9, 1, 32'd8));
      put(32'h7c, mk(I_SW,   0, 0, 9, 32'h7c));
      put(32'h80, mk(I_JALR, 14, 0, 0, 32'h85));

      // Random section
      a = 32'h84;
      for (int i = 0; i < 100; i++) begin
         k = $urandom_range(0, 99);
         if (k < 35)
            put(a, mk(op_e'(int'(I_ADD) + int'($urandom_range(0, 9))), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 31), 32'd0));
         else if (k < 52)
            put(a, mk(op_e'(int'(I_ADDI) + int'($urandom_range(0, 5))), $urandom_range(0, 31),
                      $urandom_range(0, 31), 0, simm12()));
         else if (k < 60)
            put(a, mk(op_e'(int'(I_SLLI) + int'($urandom_range(0, 2))), $urandom_range(0, 31),
                      $urandom_range(0, 31), 0, 32'($urandom_range(0, 31))));
         else if (k < 68)
            put(a, mk((k < 64) ? I_LUI : I_AUIPC, $urandom_range(0, 31), 0, 0,
                      32'($urandom_range(0, 32'hFFFFF))));
         else if (k < 78)
            put(a, mk(I_LW, $urandom_range(0, 31), $urandom_range(0, 31), 0, simm12()));
         else if (k < 88)
            put(a, mk(I_SW, 0, $urandom_range(0, 31), $urandom_range(0, 31), simm12()));
         else if (k < 96)
            put(a, mk(op_e'(int'(I_BEQ) + int'($urandom_range(0, 5))), 0, $urandom_range(0, 31),
                      $urandom_range(0, 31), ($urandom_range(0, 1) == 0) ? 32'd8 : 32'd12));
         else
            put(a, mk(I_JAL, $urandom_range(0, 31), 0, 0, 32'd8));
         a += 4;
      end
      for (int r = 1; r < 32; r++) begin
         put(a, mk(I_SW, 0, 0, r, 32'h300 + 32'(4 * r)));
         a += 4;
      end
      put(a, mk(I_JAL, 0, 0, 0, 32'd0));

      // Reset held for two cycles
      model_reset();
      repeat (2) begin
         @(negedge clk);
         chk("reset_pc", pc_out, 32'd0);
         chk("reset_we", {31'd0, write_en}, 32'd0);
      end
      reset = 1'b1;

      run_to(32'h84, 200);
      chk("ram_0x60", dram[24], 32'd7);
      chk("ram_0x64", dram[25], 32'h19);
      chk("ram_0x68", dram[26], 32'd14);
      chk("ram_0x6c", dram[27], 32'd0);
      chk("ram_0x70_skipped", dram[28], 32'hA5A5_001C);
      chk("ram_0x44_skipped", dram[17], 32'hA5A5_0011);
      chk("ram_0x78_skipped", dram[30], 32'hA5A5_001E);
      chk("ram_0x7c_skipped", dram[31], 32'hA5A5_001F);

      run_to(32'(a), 3000);
      repeat (3) step();

      // Asynchronous reset in the middle of a cycle
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_pc", pc_out, 32'd0);
      chk("async_reset_we", {31'd0, write_en}, 32'd0);
      model_reset();
      clear_prog();
      for (int r = 1; r < 32; r++) put((r - 1) * 4, mk(I_SW, 0, 0, r, 32'h300 + 32'(4 * r)));
      put(32'h7c, mk(I_JAL, 0, 0, 0, 32'd0));
      repeat (2) begin
         @(negedge clk);
         chk("held_reset_pc", pc_out, 32'd0);
      end
      reset = 1'b1;
      run_to(32'h7c, 200);
      repeat (2) step();

      for (int i = 0; i < 256; i++) chk("ram_final", dram[i], mram[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
